log_afpm_serial: RTL and testbench

Parametrised, byte-serial logarithmic (Mitchell) approximate floating-point multiplier. Successor to the fixed 16-bit top-level multiplier, with a configurable format (exponent/mantissa width), an explicit load/result handshake, IEEE-style special-value handling, and flush-to-zero underflow. It sits behind the Tiny Tapeout pin wrapper. Operand A arrives on the dedicated inputs and operand B on the bidirectional inputs, one byte per cycle. The result returns byte-serially on the dedicated outputs.

---
 rtl/log_afpm_if.sv | 20 ++
 rtl/log_afpm_serial.sv | 163 ++++++++++++++++
 tb/tb_log_afpm_serial.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/log_afpm_if.sv
// Byte-serial operand/result channel of the logarithmic FP multiplier.
// The master drives operand bytes; the slave returns result bytes and busy.
interface log_afpm_if;
    logic       in_valid;
    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       busy;

    modport master (
        output in_valid, a_byte, b_byte,
        input  out_valid, out_byte, busy
    );

    modport slave (
        input  in_valid, a_byte, b_byte,
        output out_valid, out_byte, busy
    );
endinterface

// File: rtl/log_afpm_serial.sv
// Byte-serial Mitchell (logarithmic) approximate floating-point multiplier
// with configurable exponent/mantissa widths, IEEE-style specials and flush-to-zero.
module log_afpm_serial #(
    parameter int EXP_W     = 5,
    parameter int MAN_W     = 10,
    parameter int LSB_FIRST = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    log_afpm_if.slave bus
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int NBYTES = (W + 7) / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam int ER_W   = EXP_W + 2;
    localparam int BIAS   = 2 ** (EXP_W - 1) - 1;
    localparam int EMAX   = 2 ** EXP_W - 1;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, SEND} state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [W-1:0]       a_q, b_q, res_q, res_n;
    logic               out_valid_q, out_valid_n;
    logic [7:0]         out_byte_q, out_byte_n;
    logic               busy_q, busy_n;
    logic               load_en;

    logic [CNT_W-1:0]   ld_pos, tx_idx, tx_pos;
    logic [W-1:0]       tx_word;
    logic [8*NBYTES-1:0] tx_pad;
    logic [7:0]         tx_byte;

    logic               sa, sb, sr;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   ma, mb;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [MAN_W:0]     msum;
    logic [ER_W-1:0]    er;
    logic               ovf, unf;

    // Mitchell datapath: mantissas add as log fractions, carry bumps the exponent.
    always_comb begin
        sa     = a_q[W-1];
        sb     = b_q[W-1];
        ea     = a_q[W-2:MAN_W];
        eb     = b_q[W-2:MAN_W];
        ma     = a_q[MAN_W-1:0];
        mb     = b_q[MAN_W-1:0];
        sr     = sa ^ sb;
        a_nan  = (&ea) & (|ma);
        b_nan  = (&eb) & (|mb);
        a_inf  = (&ea) & ~(|ma);
        b_inf  = (&eb) & ~(|mb);
        a_zero = ~(|ea);
        b_zero = ~(|eb);
        msum   = {1'b0, ma} + {1'b0, mb};
        er     = {2'b00, ea} + {2'b00, eb} + ER_W'(msum[MAN_W]) - ER_W'(BIAS);
        ovf    = ~er[ER_W-1] && (er >= ER_W'(EMAX));
        unf    = er[ER_W-1] || (er == '0);

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            res_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        else if (a_inf || b_inf || ovf)
            res_n = {sr, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (a_zero || b_zero || unf)
            res_n = {sr, {(EXP_W+MAN_W){1'b0}}};
        else
            res_n = {sr, er[EXP_W-1:0], msum[MAN_W-1:0]};
    end

    // Transfer index to physical byte position, and the byte to send next.
    always_comb begin
        ld_pos  = (LSB_FIRST != 0) ? cnt_q : CNT_W'(NBYTES - 1) - cnt_q;
        tx_word = (state_q == CALC) ? res_n : res_q;
        tx_idx  = (state_q == CALC) ? '0 : cnt_q;
        tx_pos  = (LSB_FIRST != 0) ? tx_idx : CNT_W'(NBYTES - 1) - tx_idx;
        tx_pad  = '0;
        tx_pad[W-1:0] = tx_word;
        tx_byte = '0;
        for (int i = 0; i < NBYTES; i++)
            if (tx_pos == CNT_W'(i)) tx_byte = tx_pad[i*8 +: 8];
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        out_valid_n = 1'b0;
        out_byte_n  = 8'h00;
        busy_n      = 1'b0;
        load_en     = 1'b0;
        unique case (state_q)
            IDLE, LOAD: begin
                if (bus.in_valid) begin
                    load_en = 1'b1;
                    if (cnt_q == CNT_W'(NBYTES - 1)) begin
                        state_n = CALC;
                        cnt_n   = '0;
                        busy_n  = 1'b1;
                    end else begin
                        state_n = LOAD;
                        cnt_n   = cnt_q + CNT_W'(1);
                    end
                end
            end
            CALC: begin
                state_n     = SEND;
                cnt_n       = CNT_W'(1);
                out_valid_n = 1'b1;
                out_byte_n  = tx_byte;
                busy_n      = 1'b1;
            end
            SEND: begin
                if (cnt_q == CNT_W'(NBYTES)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n       = cnt_q + CNT_W'(1);
                    out_valid_n = 1'b1;
                    out_byte_n  = tx_byte;
                    busy_n      = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h00;
            busy_q      <= 1'b0;
        end else if (ena) begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            out_valid_q <= out_valid_n;
            out_byte_q  <= out_byte_n;
            busy_q      <= busy_n;
            if (state_q == CALC) res_q <= res_n;
            // Bits above W-1 of the top byte are simply never stored.
            if (load_en) begin
                for (int j = 0; j < W; j++) begin
                    if (ld_pos == CNT_W'(j / 8)) begin
                        a_q[j] <= bus.a_byte[j % 8];
                        b_q[j] <= bus.b_byte[j % 8];
                    end
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_byte  = out_byte_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_log_afpm_serial.sv
// Directed bench for log_afpm_serial: three instances (default, MSB-first, 8-bit format)
// with a byte scoreboard checked on the falling edge.
module tb_log_afpm_serial;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    int         sel;
    logic       drv_valid;
    logic [7:0] drv_a, drv_b;
    int         assert_cnt = 0;
    int         fail_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic       ena_edge = 1'b0;
    logic       obs_valid, obs_busy;
    logic [7:0] obs_byte;

    log_afpm_if if0();
    log_afpm_if if1();
    log_afpm_if if2();

    assign if0.in_valid = drv_valid && (sel == 0);
    assign if1.in_valid = drv_valid && (sel == 1);
    assign if2.in_valid = drv_valid && (sel == 2);
    assign if0.a_byte = drv_a;
    assign if1.a_byte = drv_a;
    assign if2.a_byte = drv_a;
    assign if0.b_byte = drv_b;
    assign if1.b_byte = drv_b;
    assign if2.b_byte = drv_b;

    log_afpm_serial u_def (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(if0));
    log_afpm_serial #(.LSB_FIRST(0)) u_msb (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(if1));
    log_afpm_serial #(.EXP_W(4), .MAN_W(3)) u_small (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(if2));

    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            1:       begin obs_valid = if1.out_valid; obs_byte = if1.out_byte; obs_busy = if1.busy; end
            2:       begin obs_valid = if2.out_valid; obs_byte = if2.out_byte; obs_busy = if2.busy; end
            default: begin obs_valid = if0.out_valid; obs_byte = if0.out_byte; obs_busy = if0.busy; end
        endcase
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        assert_cnt++;
        assert (got === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A new output byte appears only after an edge taken with ena high.
    always @(posedge clk) ena_edge <= ena;

    always @(negedge clk) begin
        if (rst_n && ena_edge && obs_valid) begin
            if (exp_q.size() == 0) begin
                check("extra_out_byte", 16'(obs_valid), 16'(0));
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_byte", 16'(obs_byte), 16'(mon_exp));
            end
        end
    end

    function automatic int nbytes_of(input int s);
        return (s == 2) ? 1 : 2;
    endfunction

    task automatic push_expected(input int s, input logic [15:0] e);
        int nb;
        int p;
        nb = nbytes_of(s);
        for (int k = 0; k < nb; k++) begin
            p = (s == 1) ? nb - 1 - k : k;
            exp_q.push_back(e[p*8 +: 8]);
        end
    endtask

    task automatic send_operands(input int s, input logic [15:0] a, input logic [15:0] b,
                                 input bit gap, input bit stall);
        int nb;
        int p;
        nb = nbytes_of(s);
        for (int k = 0; k < nb; k++) begin
            p = (s == 1) ? nb - 1 - k : k;
            if (gap && k > 0) begin
                drv_valid = 1'b0;
                tick();
                tick();
                check("load_gap_busy", 16'(obs_busy), 16'(0));
            end
            drv_valid = 1'b1;
            drv_a = a[p*8 +: 8];
            drv_b = b[p*8 +: 8];
            if (stall) begin
                ena = 1'b0;
                tick();
                ena = 1'b1;
            end
            tick();
        end
        drv_valid = 1'b0;
    endtask

    task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] e, input bit gap, input bit stall, input bit junk);
        int nb;
        nb = nbytes_of(s);
        sel = s;
        push_expected(s, e);
        send_operands(s, a, b, gap, stall);
        drv_valid = junk;
        drv_a = 8'hFF;
        drv_b = 8'hFF;
        check("calc_busy", 16'(obs_busy), 16'(1));
        check("calc_valid", 16'(obs_valid), 16'(0));
        for (int k = 0; k < nb; k++) begin
            tick();
            check("send_valid", 16'(obs_valid), 16'(1));
            check("send_busy", 16'(obs_busy), 16'(1));
            if (stall && k == 0) begin
                ena = 1'b0;
                tick();
                tick();
                check("stall_hold_valid", 16'(obs_valid), 16'(1));
                ena = 1'b1;
            end
        end
        tick();
        check("done_valid", 16'(obs_valid), 16'(0));
        check("done_byte", 16'(obs_byte), 16'(0));
        check("done_busy", 16'(obs_busy), 16'(0));
        drv_valid = 1'b0;
        check("scoreboard_empty", 16'(exp_q.size()), 16'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        ena = 1'b1;
        sel = 0;
        drv_valid = 1'b0;
        drv_a = 8'h00;
        drv_b = 8'h00;
        tick();
        tick();
        check("rst_valid0", 16'(if0.out_valid), 16'(0));
        check("rst_byte0", 16'(if0.out_byte), 16'(0));
        check("rst_busy0", 16'(if0.busy), 16'(0));
        check("rst_valid1", 16'(if1.out_valid), 16'(0));
        check("rst_valid2", 16'(if2.out_valid), 16'(0));
        rst_n = 1'b1;
        tick();

        // Default format, LSB first
        run_op(0, 16'h44DF, 16'h483D, 16'h511C, 1'b0, 1'b0, 1'b0);
        run_op(0, 16'h3E00, 16'h3E00, 16'h4000, 1'b0, 1'b0, 1'b0);
        run_op(0, 16'hBE00, 16'h3E00, 16'hC000, 1'b0, 1'b0, 1'b0);
        run_op(0, 16'h8000, 16'h483D, 16'h8000, 1'b0, 1'b0, 1'b0);
        run_op(0, 16'h7C00, 16'h0000, 16'h7E00, 1'b0, 1'b0, 1'b0);
        run_op(0, 16'h7C00, 16'hC000, 16'hFC00, 1'b0, 1'b0, 1'b0);
        run_op(0, 16'h7E01, 16'h3C00, 16'h7E00, 1'b0, 1'b0, 1'b0);
        run_op(0, 16'h7BFF, 16'h7BFF, 16'h7C00, 1'b0, 1'b0, 1'b0);
        run_op(0, 16'h0400, 16'h0400, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_op(0, 16'h0001, 16'h3C00, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Gaps, ena stalls and in_valid pulses while busy
        run_op(0, 16'h44DF, 16'h483D, 16'h511C, 1'b1, 1'b1, 1'b1);
        run_op(0, 16'hBE00, 16'h3E00, 16'hC000, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of SEND
        sel = 0;
        exp_q.push_back(8'h1C);
        send_operands(0, 16'h44DF, 16'h483D, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midsend_rst_valid", 16'(obs_valid), 16'(0));
        check("midsend_rst_byte", 16'(obs_byte), 16'(0));
        check("midsend_rst_busy", 16'(obs_busy), 16'(0));
        check("midsend_popped", 16'(exp_q.size()), 16'(0));
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        run_op(0, 16'h3E00, 16'h3E00, 16'h4000, 1'b0, 1'b0, 1'b0);

        // MSB-first instance
        run_op(1, 16'h44DF, 16'h483D, 16'h511C, 1'b0, 1'b0, 1'b0);
        run_op(1, 16'h7C00, 16'hC000, 16'hFC00, 1'b1, 1'b1, 1'b1);

        // EXP_W=4, MAN_W=3 instance
        run_op(2, 16'h004A, 16'h003C, 16'h004E, 1'b0, 1'b0, 1'b0);
        run_op(2, 16'h004A, 16'h003C, 16'h004E, 1'b0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
